// File: rtl/uart_mmio_bridge_pkg.sv
// Shared definitions for the memory-mapped UART bridge.
// Holds the I/O-window register addresses, the sticky error bit positions
// within the status word, and helpers for address decode and status packing.
package uart_mmio_bridge_pkg;

  localparam logic [31:0] AddrTxStatus = 32'h8000_0000;
  localparam logic [31:0] AddrRxStatus = 32'h8000_0004;
  localparam logic [31:0] AddrTxData   = 32'h8000_0008;
  localparam logic [31:0] AddrRxData   = 32'h8000_000C;
  localparam logic [31:0] AddrStatus   = 32'h8000_0010;

  localparam int unsigned TxOverflowBit  = 4;
  localparam int unsigned RxUnderflowBit = 3;
  localparam int unsigned RxOverrunBit   = 2;

  typedef enum logic [2:0] {
    RegNone,
    RegTxStatus,
    RegRxStatus,
    RegTxData,
    RegRxData,
    RegStatus
  } reg_sel_e;

  typedef struct packed {
    logic tx_overflow;
    logic rx_underflow;
    logic rx_overrun;
  } sticky_t;

  // Full 32-bit compare; aliases inside the window decode to RegNone.
  function automatic reg_sel_e decode_addr(logic [31:0] a);
    reg_sel_e sel;
    unique case (a)
      AddrTxStatus: sel = RegTxStatus;
      AddrRxStatus: sel = RegRxStatus;
      AddrTxData:   sel = RegTxData;
      AddrRxData:   sel = RegRxData;
      AddrStatus:   sel = RegStatus;
      default:      sel = RegNone;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] status_word(sticky_t s);
    logic [31:0] w;
    w                 = '0;
    w[TxOverflowBit]  = s.tx_overflow;
    w[RxUnderflowBit] = s.rx_underflow;
    w[RxOverrunBit]   = s.rx_overrun;
    return w;
  endfunction

endpackage

// File: rtl/uart_mmio_bridge_sync_fifo.sv
// Synchronous FIFO used for the bridge's TX and RX byte queues.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata     enqueue request and data; ignored while full
//   pop             dequeue request; ignored while empty
//   rdata           head entry, forced to 0 while empty
//   full, empty     derived from the registered occupancy count
//   count           occupancy, log2(DEPTH)+1 bits
module uart_mmio_bridge_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign count = count_q;

  // Gating on pre-edge full/empty means a push to a full FIFO is dropped
  // even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART port for the memory stage.
// Decodes the 0x8000_00xx window, queues TX and RX bytes in FIFOs, keeps
// sticky error flags and returns a registered read word.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   addr, wdata, we, re           memory-stage address, store data, strobes
//   rdata                         read word, valid the cycle after re
//   DataIn/DataInValid/DataInReady      TX byte stream to the transmitter
//   DataOut/DataOutValid/DataOutReady   RX byte stream from the receiver
module uart_mmio_bridge
  import uart_mmio_bridge_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic [7:0]  DataIn,
  output logic        DataInValid,
  input  logic        DataInReady,
  input  logic [7:0]  DataOut,
  input  logic        DataOutValid,
  output logic        DataOutReady
);

  reg_sel_e sel;
  logic     tx_push, tx_full, tx_empty;
  logic     rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic     sticky_clr;
  sticky_t  sticky_set, sticky_q, sticky_d;
  logic [31:0] rdata_q, rdata_d;

  // Only the low byte of store data reaches the TX FIFO.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];
  logic unused_counts;
  assign unused_counts = ^{tx_count, rx_count};

  assign sel        = decode_addr(addr);
  assign tx_push    = we && (sel == RegTxData);
  assign sticky_clr = we && (sel == RegStatus);
  assign rx_pop     = re && (sel == RegRxData);

  assign DataInValid  = !tx_empty;
  assign DataOutReady = !rx_full;

  uart_mmio_bridge_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .wdata (wdata[7:0]),
    .pop   (DataInReady),
    .rdata (DataIn),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  uart_mmio_bridge_sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (DataOutValid),
    .wdata (DataOut),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_comb begin
    sticky_set.tx_overflow  = tx_push && tx_full;
    sticky_set.rx_underflow = rx_pop && rx_empty;
    sticky_set.rx_overrun   = DataOutValid && rx_full;
    // Set wins over a same-cycle clear.
    sticky_d = sticky_clr ? '0 : sticky_q;
    sticky_d = sticky_d | sticky_set;
  end

  // Reads see pre-edge occupancy and flags.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      case (sel)
        RegTxStatus: rdata_d = {31'd0, !tx_full};
        RegRxStatus: rdata_d = {31'd0, !rx_empty};
        RegRxData:   rdata_d = {24'd0, rx_head};
        RegStatus:   rdata_d = status_word(sticky_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
      rdata_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
module tb_uart_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  DataIn;
  logic        DataInValid;
  logic        DataInReady = 1'b0;
  logic [7:0]  DataOut = '0;
  logic        DataOutValid = 1'b0;
  logic        DataOutReady;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_mmio_bridge #(
    .TX_DEPTH (4),
    .RX_DEPTH (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .wdata        (wdata),
    .we           (we),
    .re           (re),
    .rdata        (rdata),
    .DataIn       (DataIn),
    .DataInValid  (DataInValid),
    .DataInReady  (DataInReady),
    .DataOut      (DataOut),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    re   = 1'b1;
    tick();
    re   = 1'b0;
    d    = rdata;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    // Power-on reset
    #2;
    check("reset_rdata", rdata, 32'h0);
    check("reset_txvalid", {31'd0, DataInValid}, 32'h0);
    check("reset_rxready", {31'd0, DataOutReady}, 32'h1);
    check("reset_datain", {24'd0, DataIn}, 32'h0);
    #11 rst_n = 1'b1;
    tick();
    cpu_read(32'h8000_0000, rd);
    check("reset_txstat", rd, 32'h1);
    cpu_read(32'h8000_0010, rd);
    check("reset_sticky", rd, 32'h0);

    // TX path: one-cycle visibility, back-to-back drain
    DataInReady = 1'b1;
    cpu_write(32'h8000_0008, 32'hFFFF_FF41);
    check("tx_first_valid", {31'd0, DataInValid}, 32'h1);
    check("tx_first_byte", {24'd0, DataIn}, 32'h41);
    cpu_write(32'h8000_0008, 32'h0000_0042);
    check("tx_second_valid", {31'd0, DataInValid}, 32'h1);
    check("tx_second_byte", {24'd0, DataIn}, 32'h42);
    tick();
    check("tx_drained", {31'd0, DataInValid}, 32'h0);

    // TX overflow: fifth store dropped
    DataInReady = 1'b0;
    for (int i = 0; i < 5; i++) cpu_write(32'h8000_0008, 32'h10 + i);
    cpu_read(32'h8000_0000, rd);
    check("tx_full_stat", rd, 32'h0);
    cpu_read(32'h8000_0010, rd);
    check("tx_overflow", rd, 32'h10);
    DataInReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("tx_drain_valid", {31'd0, DataInValid}, 32'h1);
      check("tx_drain_byte", {24'd0, DataIn}, 32'h10 + i);
      tick();
    end
    check("tx_drain_done", {31'd0, DataInValid}, 32'h0);
    cpu_write(32'h8000_0010, 32'h0);
    cpu_read(32'h8000_0010, rd);
    check("clear_tx_overflow", rd, 32'h0);

    // Full decode: aliased addresses ignored
    cpu_write(32'h0000_0008, 32'h77);
    check("alias_write", {31'd0, DataInValid}, 32'h0);
    cpu_read(32'h8000_0014, rd);
    check("unmapped_read", rd, 32'h0);

    // RX path
    DataOut = 8'h5A;
    DataOutValid = 1'b1;
    tick();
    DataOutValid = 1'b0;
    cpu_read(32'h8000_0004, rd);
    check("rx_stat_full", rd, 32'h1);
    cpu_read(32'h8000_000C, rd);
    check("rx_pop_5a", rd, 32'h5A);
    repeat (2) tick();
    check("rdata_hold", rdata, 32'h5A);
    cpu_read(32'h8000_0004, rd);
    check("rx_stat_empty", rd, 32'h0);

    // RX underflow
    cpu_read(32'h8000_000C, rd);
    check("rx_underflow_data", rd, 32'h0);
    cpu_read(32'h8000_0010, rd);
    check("rx_underflow_flag", rd, 32'h08);

    // RX overrun: ninth byte refused
    for (int i = 0; i < 8; i++) begin
      DataOut = 8'h80 + 8'(i);
      DataOutValid = 1'b1;
      tick();
    end
    DataOut = 8'h88;
    check("rx_ready_low", {31'd0, DataOutReady}, 32'h0);
    tick();
    DataOutValid = 1'b0;
    cpu_read(32'h8000_0010, rd);
    check("rx_overrun_flag", rd, 32'h0C);
    cpu_write(32'h8000_0010, 32'hDEAD_BEEF);
    cpu_read(32'h8000_0010, rd);
    check("sticky_clear", rd, 32'h0);

    // Drain seven, leaving 0x87 as the only entry
    for (int i = 0; i < 7; i++) begin
      cpu_read(32'h8000_000C, rd);
      check("rx_drain", rd, 32'h80 + i);
    end
    check("rx_ready_back", {31'd0, DataOutReady}, 32'h1);

    // Simultaneous receiver push and CPU pop with one entry
    DataOut = 8'h99;
    DataOutValid = 1'b1;
    cpu_read(32'h8000_000C, rd);
    DataOutValid = 1'b0;
    check("simul_old_head", rd, 32'h87);
    cpu_read(32'h8000_0004, rd);
    check("simul_not_empty", rd, 32'h1);
    cpu_read(32'h8000_000C, rd);
    check("simul_new_head", rd, 32'h99);
    cpu_read(32'h8000_0004, rd);
    check("simul_empty", rd, 32'h0);
    cpu_read(32'h8000_0010, rd);
    check("simul_no_flags", rd, 32'h0);

    // Asynchronous reset mid-transfer
    DataInReady = 1'b0;
    cpu_write(32'h8000_0008, 32'hA5);
    cpu_read(32'h8000_0000, rd);
    check("pre_reset_valid", {31'd0, DataInValid}, 32'h1);
    DataOut = 8'h33;
    DataOutValid = 1'b1;
    tick();
    DataOutValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_txvalid", {31'd0, DataInValid}, 32'h0);
    check("async_datain", {24'd0, DataIn}, 32'h0);
    check("async_rdata", rdata, 32'h0);
    check("async_rxready", {31'd0, DataOutReady}, 32'h1);
    #2 rst_n = 1'b1;
    tick();
    cpu_read(32'h8000_0000, rd);
    check("post_reset_txstat", rd, 32'h1);
    cpu_read(32'h8000_0004, rd);
    check("post_reset_rxstat", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_mmio_bridge.md
# uart_mmio_bridge

Memory-mapped UART port for the MIPS150 datapath, sitting directly downstream of the control decoder's UART strobes (REUART/WEUART) in the memory stage. Decodes the 0x8000_00xx I/O window, buffers transmit bytes and received bytes in small FIFOs, and drives the ready/valid handshake of the UART transmitter and receiver. Returns a registered 32-bit read word to the write-back mux alongside data-memory read data.

## Interface
- `TX_DEPTH`, 4: transmit FIFO entries, power of two, ≥2.
- `RX_DEPTH`, 8: receive FIFO entries, power of two, ≥2.

- `clk`  in  1  single system clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `addr`  in  32  memory-stage effective address.
- `wdata`  in  32  store data; only [7:0] used.
- `we`  in  1  store strobe (WEUART), one cycle per store.
- `re`  in  1  load strobe for the UART window (REUART or any MemRead hitting 0x8000_00xx).
- `rdata`  out  32  registered read word, valid the cycle after `re`.
- `DataIn`  out  8  byte to UART transmitter.
- `DataInValid`  out  1  TX FIFO head valid.
- `DataInReady`  in  1  transmitter accepts byte.
- `DataOut`  in  8  byte from UART receiver.
- `DataOutValid`  in  1  receiver byte valid.
- `DataOutReady`  out  1  RX FIFO can accept.

## Operation
- Register map, decoded on full 32-bit `addr`; anything else is ignored (read returns 0, write has no effect):
  - 0x8000_0000 R: bit0 = TX FIFO not full.
  - 0x8000_0004 R: bit0 = RX FIFO not empty.
  - 0x8000_0008 W: push `wdata[7:0]` into TX FIFO.
  - 0x8000_000C R: pop RX FIFO; returns head byte zero-extended.
  - 0x8000_0010 R: {bit4 = tx_overflow, bit3 = rx_underflow, bit2 = rx_overrun, bits1:0 = 0}. W (any data): clears all three sticky bits.
- TX push while TX FIFO full: byte dropped, `tx_overflow` set.
- RX pop while RX FIFO empty: `rdata` = 0, no pointer change, `rx_underflow` set.
- `DataOutValid` high while RX FIFO full: byte not accepted (`DataOutReady` = 0); `rx_overrun` set. The receiver holds or drops per its own contract.
- TX drain: `DataInValid` = TX not empty, `DataIn` = TX head; pop when `DataInValid && DataInReady`.
- RX fill: `DataOutReady` = RX not full; push when `DataOutValid && DataOutReady`.
- `we` and `re` both high in the same cycle: both actions take place; `re` returns read data per map.
- Sticky set and clear in the same cycle: set wins.

## Timing
- Reset (async assert, sync-safe deassert by top level): FIFOs empty, sticky bits 0, `rdata` = 0, `DataInValid` = 0, `DataOutReady` = 1, `DataIn` = 0.
- Read latency 1: `rdata` updates on the edge after `re` and holds until the next `re`.
- Status reads sample occupancy before any same-cycle push or pop.
- Full and empty are evaluated on registered occupancy before the edge, so simultaneous CPU push and drain pop on a full TX FIFO still drops the push. Simultaneous pop and push on a non-empty, non-full FIFO leave the count unchanged.
- A store becomes visible on `DataInValid` one cycle after `we` (empty FIFO case).
- A received byte is visible to a status read one cycle after the handshake.
- Pointers wrap modulo depth. Occupancy counter is log2(DEPTH)+1 bits.
- Reset asserted mid-transfer: FIFO contents are discarded; `DataInValid` drops asynchronously.

## Structure
- Shared header `UARTmap.vh`: the five address constants and the sticky-bit positions. Included by this block and the control decoder.
- One sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated as TX (8×TX_DEPTH) and RX (8×RX_DEPTH).
- Top level holds the address decode, sticky bits and `rdata` register.

## Test plan
- Reset: pulse `rst_n` low mid-cycle → all outputs at reset values immediately; status read 0x8000_0000 returns 1.
- TX path: stores 0x41, 0x42 to 0x8000_0008 with `DataInReady`=1 → `DataIn` shows 0x41 then 0x42 on consecutive cycles, starting one cycle after the first `we`.
- TX overflow: `DataInReady`=0, five stores with TX_DEPTH=4 → 0x8000_0000 reads 0; 0x8000_0010 reads 0x10; after release, exactly the first four bytes drain.
- RX path: receiver delivers 0x5A → 0x8000_0004 reads 1; load 0x8000_000C returns 0x0000_005A; next status read returns 0.
- RX underflow and overrun: pop when empty → `rdata`=0 and bit3 set. Offer 9 bytes with RX_DEPTH=8 → `DataOutReady` drops after the 8th and bit2 is set. Store to 0x8000_0010 → sticky bits read 0.
- Simultaneous events: `DataOutValid` push and CPU pop in the same cycle with RX at 1 entry → occupancy stays 1; popped byte is the old head.
